data_sampling_mv: RTL and testbench
===================================

Name: data_sampling_mv

Overview:
Parametrised majority-vote bit sampler for the UART receiver. It is the successor of the fixed 3-sample data sampler.
- Takes 1, 3 or 5 samples of RX_IN, selectable at run time, centred on the mid-bit edge count.
- Votes on them using the current sample, not a stale one.
- Reports a one-cycle valid strobe and a noise flag when the samples disagree.
- Sits between the edge/bit counter and the deserializer/parity/stop checkers.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt.
MAX_SAMPLES, 5, largest vote window supported (odd, 1..7); sets ones-counter width to clog2(MAX_SAMPLES+1).

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous active-high reset.
data_sample_enable  input  1  sampling permitted; low aborts any open window.
RX_IN  input  1  serial line, already synchronised upstream.
prescale  input  PRESCALE_W  oversampling ratio (edges per bit); legal 1..2^PRESCALE_W-1.
edge_cnt  input  PRESCALE_W  current edge index in bit, 0..prescale-1.
sample_mode  input  2  00: 1 sample; 01: 3; 10: 5; 11: treated as 01.
sampled_bit  output  1  voted bit value.
sample_valid  output  1  one-cycle strobe: sampled_bit/noise_err updated this cycle.
noise_err  output  1  samples of last vote not unanimous; valid with sample_valid, held until next vote.

Behaviour:
- Reset (async, RST=1):
  - sampled_bit=1 (idle line).
  - sample_valid=0, noise_err=0.
  - ones counter, sample counter and window-open flag all cleared.
- Window geometry, all arithmetic at PRESCALE_W bits, no wrap:
  - mid = prescale>>1.
  - k_req = 0/1/2 for mode 00/01/10; mode 11 gives k_req=1; k_req is also capped at (MAX_SAMPLES-1)/2.
  - k = min(k_req, mid, prescale-1-mid), so the window never underflows 0 or exceeds prescale-1.
  - Window start S = mid-k. Window end E = mid+k. N = 2k+1.
- Operation, only while data_sample_enable=1:
  - edge_cnt==S: latch k/N for this window, open the window, ones=RX_IN, seen=1. sample_mode/prescale changes after this are ignored until the next window.
  - S<edge_cnt<E with window open: ones+=RX_IN, seen+=1.
  - edge_cnt==E with window open: total = ones + RX_IN (for N=1, S==E, so total=RX_IN directly).
    - sampled_bit <= (total > k).
    - noise_err <= (total!=0 && total!=N).
    - sample_valid <= 1 for exactly one cycle.
    - Window closes.
- Latency: outputs registered on the edge where edge_cnt==E. They are visible the cycle after E is presented.
- sample_valid is 0 in every other cycle, including cycles where edge_cnt is held at E for more than one cycle. A window fires at most once.
- data_sample_enable=0: window closes immediately, ones/seen cleared, no strobe. sampled_bit and noise_err hold.
- Re-enable mid-bit (edge_cnt>S): no vote for that bit. The next vote occurs at the next S..E sequence.
- edge_cnt skipping values inside the window: only edges actually presented are counted. The vote still uses the fixed threshold k at E.
- prescale=0: illegal; no window ever opens; outputs hold.
- prescale=1: k=0, S=E=0, single sample every edge_cnt==0 cycle.
- RST asserted mid-window: immediate return to reset values; no strobe on release.

Test Plan:
- prescale=8, mode=01, RX_IN=1,0,1 at edge_cnt 3,4,5 -> the cycle after edge_cnt=5: sampled_bit=1, noise_err=1, sample_valid=1 for one cycle.
- prescale=16, mode=10, RX_IN=0 at edge 6, 1 at edges 7..10 -> sampled_bit=1, noise_err=1. Repeat with all five samples 0 -> sampled_bit=0, noise_err=0.
- prescale=8, mode=00, RX_IN=0 only at edge 4 -> sampled_bit=0, noise_err=0, valid the cycle after edge_cnt=4. Edges 3/5 values ignored.
- prescale=2, mode=10 (k clamps to 0, window at edge 1) -> single-sample vote at edge_cnt=1. Then prescale=32, mode=11 -> window edges 15..17, 3-sample vote.
- data_sample_enable dropped at edge 4 of a prescale=8 mode=01 window -> no sample_valid. Re-enabled at edge 5 -> no vote until next bit's edges 3..5; sampled_bit unchanged meanwhile.
- RST pulsed at edge 4 mid-window -> sampled_bit=1, noise_err=0, sample_valid=0. Next full window votes correctly from fresh counts.

Source files
------------

// File: rtl/data_sampling_mv.sv
// Majority-vote bit sampler for the UART receiver: takes 1, 3 or 5 samples of
// RX_IN centred on the mid-bit edge, votes on them and flags disagreement.
module data_sampling_mv #(
  parameter int PRESCALE_W  = 6,
  parameter int MAX_SAMPLES = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  data_sample_enable,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [1:0]            sample_mode,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err
);

  localparam int CNT_W = $clog2(MAX_SAMPLES + 1);
  localparam logic [PRESCALE_W-1:0] ZERO_P = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] ONE_P  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] TWO_P  = PRESCALE_W'(2'd2);
  localparam logic [PRESCALE_W-1:0] K_CAP  = PRESCALE_W'((MAX_SAMPLES - 1) / 2);
  localparam logic [CNT_W-1:0]      ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Window geometry derived from the live prescale / sample_mode
  logic [PRESCALE_W-1:0] mid_s;
  logic [PRESCALE_W-1:0] hi_s;
  logic [PRESCALE_W-1:0] k_req_s;
  logic [PRESCALE_W-1:0] k_cap_s;
  logic [PRESCALE_W-1:0] k_mid_s;
  logic [PRESCALE_W-1:0] k_s;
  logic [PRESCALE_W-1:0] s_s;
  logic [PRESCALE_W-1:0] e_s;
  logic                  legal_s;

  // Geometry selected for the current cycle (latched once a window is open)
  logic [PRESCALE_W-1:0] cur_s_s;
  logic [PRESCALE_W-1:0] cur_e_s;
  logic [CNT_W-1:0]      cur_k_s;
  logic [CNT_W-1:0]      cur_n_s;

  logic [CNT_W-1:0]      rx_c_s;
  logic [CNT_W-1:0]      total_s;
  logic                  fire_s;

  logic                  open_q, open_d;
  logic [CNT_W-1:0]      ones_q, ones_d;
  logic [CNT_W-1:0]      seen_q, seen_d;
  logic [PRESCALE_W-1:0] s_q, s_d;
  logic [PRESCALE_W-1:0] e_q, e_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic                  bit_q, bit_d;
  logic                  valid_q, valid_d;
  logic                  noise_q, noise_d;

  // Half-width k clamped so the window stays inside 0..prescale-1
  always_comb begin
    mid_s   = prescale >> 1'b1;
    hi_s    = prescale - ONE_P - mid_s;
    legal_s = (prescale != ZERO_P);
    case (sample_mode)
      2'b00:   k_req_s = ZERO_P;
      2'b01:   k_req_s = ONE_P;
      2'b10:   k_req_s = TWO_P;
      default: k_req_s = ONE_P;
    endcase
    k_cap_s = (k_req_s > K_CAP) ? K_CAP : k_req_s;
    k_mid_s = (mid_s < k_cap_s) ? mid_s : k_cap_s;
    k_s     = (hi_s < k_mid_s) ? hi_s : k_mid_s;
    s_s     = mid_s - k_s;
    e_s     = mid_s + k_s;
  end

  // Once open, a window ignores later prescale / mode changes
  always_comb begin
    if (open_q) begin
      cur_s_s = s_q;
      cur_e_s = e_q;
      cur_k_s = k_q;
      cur_n_s = n_q;
    end else begin
      cur_s_s = s_s;
      cur_e_s = e_s;
      cur_k_s = CNT_W'(k_s);
      cur_n_s = CNT_W'(k_s) + CNT_W'(k_s) + ONE_C;
    end
  end

  // Sample accumulation and the vote on the closing edge
  always_comb begin
    open_d  = open_q;
    ones_d  = ones_q;
    seen_d  = seen_q;
    s_d     = s_q;
    e_d     = e_q;
    k_d     = k_q;
    n_d     = n_q;
    bit_d   = bit_q;
    noise_d = noise_q;
    valid_d = 1'b0;
    rx_c_s  = {{(CNT_W-1){1'b0}}, RX_IN};
    total_s = ones_q + rx_c_s;
    fire_s  = 1'b0;

    if (!data_sample_enable) begin
      open_d = 1'b0;
      ones_d = ZERO_C;
      seen_d = ZERO_C;
    end else if (!open_q && !legal_s) begin
      open_d = 1'b0;
    end else if (edge_cnt == cur_s_s) begin
      if (cur_s_s == cur_e_s) begin
        total_s = rx_c_s;
        fire_s  = 1'b1;
      end else begin
        open_d = 1'b1;
        s_d    = cur_s_s;
        e_d    = cur_e_s;
        k_d    = cur_k_s;
        n_d    = cur_n_s;
        ones_d = rx_c_s;
        seen_d = ONE_C;
      end
    end else if (open_q && (edge_cnt == cur_e_s)) begin
      fire_s = 1'b1;
    end else if (open_q && (edge_cnt > cur_s_s) && (edge_cnt < cur_e_s)) begin
      ones_d = ones_q + rx_c_s;
      seen_d = seen_q + ONE_C;
    end else begin
      open_d = open_q;
    end

    if (fire_s) begin
      bit_d   = (total_s > cur_k_s);
      noise_d = (total_s != ZERO_C) && (total_s != cur_n_s);
      valid_d = 1'b1;
      open_d  = 1'b0;
      ones_d  = ZERO_C;
      seen_d  = ZERO_C;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; line idles high out of reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      open_q  <= 1'b0;
      ones_q  <= ZERO_C;
      seen_q  <= ZERO_C;
      s_q     <= ZERO_P;
      e_q     <= ZERO_P;
      k_q     <= ZERO_C;
      n_q     <= ZERO_C;
      bit_q   <= 1'b1;
      valid_q <= 1'b0;
      noise_q <= 1'b0;
    end else begin
      open_q  <= open_d;
      ones_q  <= ones_d;
      seen_q  <= seen_d;
      s_q     <= s_d;
      e_q     <= e_d;
      k_q     <= k_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      noise_q <= noise_d;
    end
  end

  assign sampled_bit  = bit_q;
  assign sample_valid = valid_q;
  assign noise_err    = noise_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Bench for data_sampling_mv: directed vector table, multi-cycle corner
// sequences and randomized bits checked against a window/vote model.
module tb_data_sampling_mv;

  localparam int KMAX = 2;

  logic       CLK;
  logic       RST;
  logic       data_sample_enable;
  logic       RX_IN;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [1:0] sample_mode;
  logic       sampled_bit;
  logic       sample_valid;
  logic       noise_err;

  int checks   = 0;
  int failures = 0;
  int vcnt;
  int v_edge;

  data_sampling_mv dut (
    .CLK                (CLK),
    .RST                (RST),
    .data_sample_enable (data_sample_enable),
    .RX_IN              (RX_IN),
    .prescale           (prescale),
    .edge_cnt           (edge_cnt),
    .sample_mode        (sample_mode),
    .sampled_bit        (sampled_bit),
    .sample_valid       (sample_valid),
    .noise_err          (noise_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          p;
    logic [1:0]  m;
    logic [63:0] rx;
    int          e;
    logic        b;
    logic        n;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int e, input logic rx, input logic en);
    edge_cnt           = 6'(e);
    RX_IN              = rx;
    data_sample_enable = en;
    @(posedge CLK);
    #1;
    if (sample_valid) begin
      vcnt++;
      v_edge = e;
    end
  endtask

  // One bit period: edges 0..p-1, enable low at edge dis, edge hold_e repeated hold_n extra times
  task automatic run_bit(input int p, input logic [1:0] m, input logic [63:0] rxv,
                         input int dis, input int hold_e, input int hold_n);
    prescale    = 6'(p);
    sample_mode = m;
    vcnt        = 0;
    v_edge      = -1;
    for (int e = 0; e < p; e++) begin
      for (int r = 0; r <= ((e == hold_e) ? hold_n : 0); r++) begin
        cyc(e, rxv[e], (e != dis));
      end
    end
  endtask

  function automatic void model(input int p, input int m, input logic [63:0] rxv, input int dis,
                                output bit fire, output int e, output bit b, output bit n);
    int mid, kr, k, s, ones;
    fire = 1'b0; e = -1; b = 1'b0; n = 1'b0;
    if (p < 1) return;
    mid = p / 2;
    kr  = (m == 0) ? 0 : ((m == 2) ? 2 : 1);
    if (kr > KMAX) kr = KMAX;
    k = kr;
    if (mid < k) k = mid;
    if (p - 1 - mid < k) k = p - 1 - mid;
    s = mid - k;
    e = mid + k;
    if (dis >= s && dis <= e) return;
    ones = 0;
    for (int i = s; i <= e; i++) ones += int'(rxv[i]);
    fire = 1'b1;
    b    = (ones > k);
    n    = (ones != 0) && (ones != 2 * k + 1);
  endfunction

  vec_t tbl[10];

  initial begin
    bit fire, mb, mn;
    int me, p, m, dis;
    logic [63:0] rxv;
    bit exp_b, exp_n;

    tbl[0] = '{8,  2'b01, 64'h28,                 5,  1'b1, 1'b1};
    tbl[1] = '{16, 2'b10, 64'h0780,               10, 1'b1, 1'b1};
    tbl[2] = '{16, 2'b10, 64'hF83F,               10, 1'b0, 1'b0};
    tbl[3] = '{8,  2'b00, 64'hEF,                 4,  1'b0, 1'b0};
    tbl[4] = '{2,  2'b10, 64'h2,                  1,  1'b1, 1'b0};
    tbl[5] = '{32, 2'b11, 64'h18000,              17, 1'b1, 1'b1};
    tbl[6] = '{5,  2'b10, 64'h03,                 4,  1'b0, 1'b1};
    tbl[7] = '{1,  2'b01, 64'h1,                  0,  1'b1, 1'b0};
    tbl[8] = '{3,  2'b01, 64'h6,                  2,  1'b1, 1'b1};
    tbl[9] = '{63, 2'b10, 64'hFFFFFFFFFFFFFFFF,   33, 1'b1, 1'b0};

    RST = 1'b1; data_sample_enable = 1'b0; RX_IN = 1'b1;
    prescale = 6'd8; edge_cnt = 6'd0; sample_mode = 2'b01;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_bit", int'(sampled_bit), 1);
    chk("reset_valid", int'(sample_valid), 0);
    chk("reset_noise", int'(noise_err), 0);
    RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_bit(tbl[i].p, tbl[i].m, tbl[i].rx, 99, 99, 0);
      chk($sformatf("tbl%0d_strobes", i), vcnt, 1);
      chk($sformatf("tbl%0d_edge", i), v_edge, tbl[i].e);
      chk($sformatf("tbl%0d_bit", i), int'(sampled_bit), int'(tbl[i].b));
      chk($sformatf("tbl%0d_noise", i), int'(noise_err), int'(tbl[i].n));
    end

    // Enable dropped at edge 4 mid-window, back at 5: that bit is lost
    run_bit(8, 2'b01, 64'hFF, 99, 99, 0);
    chk("en_pre_bit", int'(sampled_bit), 1);
    run_bit(8, 2'b01, 64'h00, 4, 99, 0);
    chk("en_drop_strobes", vcnt, 0);
    chk("en_drop_hold_bit", int'(sampled_bit), 1);
    run_bit(8, 2'b01, 64'h00, 99, 99, 0);
    chk("en_next_strobes", vcnt, 1);
    chk("en_next_bit", int'(sampled_bit), 0);

    // Edge held at E for three cycles fires once
    run_bit(8, 2'b01, 64'hFF, 99, 5, 2);
    chk("hold_strobes", vcnt, 1);
    chk("hold_bit", int'(sampled_bit), 1);

    // RST mid-window
    run_bit(8, 2'b01, 64'h20, 99, 99, 0);
    chk("rst_pre_bit", int'(sampled_bit), 0);
    chk("rst_pre_noise", int'(noise_err), 1);
    vcnt = 0;
    for (int e = 0; e < 4; e++) cyc(e, 1'b1, 1'b1);
    edge_cnt = 6'd4; RX_IN = 1'b1;
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_bit", int'(sampled_bit), 1);
    chk("rst_mid_noise", int'(noise_err), 0);
    chk("rst_mid_valid", int'(sample_valid), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int e = 5; e < 8; e++) cyc(e, 1'b1, 1'b1);
    chk("rst_release_strobes", vcnt, 0);
    run_bit(8, 2'b01, 64'h10, 99, 99, 0);
    chk("rst_next_strobes", vcnt, 1);
    chk("rst_next_bit", int'(sampled_bit), 0);
    chk("rst_next_noise", int'(noise_err), 1);

    // Mode/prescale change after the window opened is ignored
    run_bit(8, 2'b01, 64'hFF, 99, 99, 0);
    prescale = 6'd16; sample_mode = 2'b10; vcnt = 0; v_edge = -1;
    for (int e = 0; e < 16; e++) begin
      if (e == 7) begin
        sample_mode = 2'b00;
        prescale    = 6'd8;
      end
      cyc(e, (e == 6 || e == 7), 1'b1);
    end
    chk("latch_strobes", vcnt, 1);
    chk("latch_edge", v_edge, 10);
    chk("latch_bit", int'(sampled_bit), 0);
    chk("latch_noise", int'(noise_err), 1);

    // prescale=0 never opens a window
    prescale = 6'd0; vcnt = 0;
    for (int e = 0; e < 8; e++) cyc(e, 1'($urandom_range(0, 1)), 1'b1);
    chk("p0_strobes", vcnt, 0);
    chk("p0_hold_bit", int'(sampled_bit), 0);

    // Randomized bits against the model
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_b = 1'b1; exp_n = 1'b0;
    for (int t = 0; t < 250; t++) begin
      p   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(7, 63));
      m   = int'($urandom_range(0, 3));
      rxv = {$urandom, $urandom};
      dis = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, p - 1)) : 99;
      model(p, m, rxv, dis, fire, me, mb, mn);
      run_bit(p, 2'(m), rxv, dis, 99, 0);
      if (fire) begin
        exp_b = mb;
        exp_n = mn;
        chk($sformatf("rnd%0d_edge", t), v_edge, me);
      end
      chk($sformatf("rnd%0d_strobes", t), vcnt, fire ? 1 : 0);
      chk($sformatf("rnd%0d_bit", t), int'(sampled_bit), int'(exp_b));
      chk($sformatf("rnd%0d_noise", t), int'(noise_err), int'(exp_n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
